randombytes_gen: RTL



---
 rtl/randombytes_pkg.sv | 23 ++
 rtl/xorshift64_step.sv | 17 +
 rtl/randombytes_gen.sv | 101 ++++++++++
 3 files changed

// File: rtl/randombytes_pkg.sv
// Shared constants and FSM state type for the randombytes generator.
// Used by randombytes_gen and xorshift64_step.
package randombytes_pkg;

    localparam int WORD_W = 64;

    localparam logic [WORD_W-1:0] DEFAULT_SEED =
        64'h9E3779B97F4A7C15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } rb_state_t;

    // A zero state would lock xorshift at zero forever.
    function automatic logic [WORD_W-1:0] seed_fix(
        input logic [WORD_W-1:0] s
    );
        return (s == '0) ? DEFAULT_SEED : s;
    endfunction

endpackage

// File: rtl/xorshift64_step.sv
// One combinational xorshift64 step (13, 7, 17).
// Shared with other samplers that need the same sequence.
module xorshift64_step
    import randombytes_pkg::*;
(
    input  logic [WORD_W-1:0] i_x,
    output logic [WORD_W-1:0] o_y
);

    logic [WORD_W-1:0] w_a;
    logic [WORD_W-1:0] w_b;

    assign w_a = i_x ^ (i_x << 13);
    assign w_b = w_a ^ (w_a >> 7);
    assign o_y = w_b ^ (w_b << 17);

endmodule

// File: rtl/randombytes_gen.sv
// Seedable pseudo-random byte generator, one 64-bit word per cycle.
// Optional valid/ready word stream under RANDOMBYTES_STREAM_EN.
module randombytes_gen
    import randombytes_pkg::*;
#(
    parameter int OUT_BYTES = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_seed_load,
    input  logic [WORD_W-1:0]      i_seed_in,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_random_done,
    output logic [OUT_BYTES*8-1:0] o_rand_out,
    output logic                   o_word_valid,
    input  logic                   i_word_ready,
    output logic [WORD_W-1:0]      o_word_data,
    output logic                   o_word_last
);

    localparam int NWORDS = OUT_BYTES / 8;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int BUF_W  = OUT_BYTES * 8;

    rb_state_t         r_fsm;
    logic [WORD_W-1:0] r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [BUF_W-1:0]  r_rand_out;

    logic [WORD_W-1:0] w_next;
    logic              w_accept;
    logic              w_last_idx;
    logic              w_gen;

    xorshift64_step u_step (
        .i_x (r_state),
        .o_y (w_next)
    );

    assign w_gen      = (r_fsm == GEN);
    assign w_last_idx = (r_idx == IDX_W'(NWORDS - 1));

`ifdef RANDOMBYTES_STREAM_EN
    assign w_accept     = w_gen && i_word_ready;
    assign o_word_valid = w_gen;
    assign o_word_data  = w_next;
    assign o_word_last  = w_gen && w_last_idx;
`else
    logic w_unused_ready;
    assign w_unused_ready = i_word_ready;
    assign w_accept       = w_gen;
    assign o_word_valid   = 1'b0;
    assign o_word_data    = '0;
    assign o_word_last    = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fsm      <= IDLE;
            r_state    <= DEFAULT_SEED;
            r_idx      <= '0;
            r_rand_out <= '0;
        end else begin
            unique case (r_fsm)
                IDLE: begin
                    if (i_seed_load) begin
                        r_state <= seed_fix(i_seed_in);
                    end
                    if (i_start) begin
                        r_fsm      <= GEN;
                        r_idx      <= '0;
                        r_rand_out <= '0;
                    end
                end
                GEN: begin
                    if (w_accept) begin
                        r_state <= w_next;
                        r_rand_out[int'(r_idx)*WORD_W +: WORD_W]
                            <= w_next;
                        r_idx <= r_idx + 1'b1;
                        if (w_last_idx) begin
                            r_fsm <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_fsm <= IDLE;
                end
                default: begin
                    r_fsm <= IDLE;
                end
            endcase
        end
    end

    assign o_busy        = (r_fsm != IDLE);
    assign o_random_done = (r_fsm == DONE);
    assign o_rand_out    = r_rand_out;

endmodule
